// File: rtl/csr_machine.sv
// Machine-mode CSR file for the RV32 core.
//  - One combinational read port (decode) and one write port (writeback).
//  - cycle/instret/HPM counters with mcountinhibit, mtval, mtvec with optional
//    vectored mode, 2-flop synchronised interrupt lines and priority resolution.
// Ports:
//  clk, rst_n                      clock, asynchronous active-low reset
//  read_address/read_data          CSR read port; readable/writeable flag the address
//  write_enable/address/data       CSR write port
//  retired, hpm_event              counter increment strobes
//  traped, mret, ecp, trap_cause,
//  interupt, trap_value            trap / return control from the pipeline
//  ext_irq, timer_irq, soft_irq    raw asynchronous interrupt lines
//  irq_pending, irq_cause          pending enabled interrupt to writeback
//  trap_vector, mret_vector        redirect targets for fetch

// One counter: each 32-bit half can be replaced by a CSR write, which
// suppresses that cycle's increment and leaves the other half untouched.
module csr_counter #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          inhibit,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic [31:0]   wdata,
    output logic [W-1:0]  cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo)                cnt_d[31:0]    = wdata;
        else if (wr_hi)           cnt_d[W-1:32]  = wdata[W-33:0];
        else if (inc && !inhibit) cnt_d          = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module csr_machine #(
    parameter int          NUM_HPM       = 4,
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [31:0] HART_ID       = 32'h0,
    parameter logic [31:0] MTVEC_RESET   = 32'h0,
    parameter bit          VECTORED_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        read_address,
    output logic [31:0]        read_data,
    output logic               readable,
    output logic               writeable,
    input  logic               write_enable,
    input  logic [11:0]        write_address,
    input  logic [31:0]        write_data,
    input  logic               retired,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               traped,
    input  logic               mret,
    input  logic [31:0]        ecp,
    input  logic [3:0]         trap_cause,
    input  logic               interupt,
    input  logic [31:0]        trap_value,
    input  logic               ext_irq,
    input  logic               timer_irq,
    input  logic               soft_irq,
    output logic               irq_pending,
    output logic [3:0]         irq_cause,
    output logic [31:0]        trap_vector,
    output logic [31:0]        mret_vector
);
    // Counter slot k: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
    localparam int NCNT = NUM_HPM + 2;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
    localparam logic [1:0]  MODE_RST = (MTVEC_RESET[1:0] == 2'b01 && VECTORED_EN) ? 2'b01 : 2'b00;

    // Low 5 address bits of counter slot k (0xB00, 0xB02, 0xB03+i).
    function automatic logic [4:0] cnt_off(input int k);
        return (k == 0) ? 5'd0 : 5'(k + 1);
    endfunction

    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]  mie_en_q, mie_en_d;         // {MEIE, MTIE, MSIE}
    logic [29:0] mtvec_base_q, mtvec_base_d;
    logic [1:0]  mtvec_mode_q, mtvec_mode_d;
    logic [31:0] inhibit_q, inhibit_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic        mcause_irq_q, mcause_irq_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
    logic [31:0] mtval_q, mtval_d;
    logic [2:0]  irq_sync_q, irq_sync_d;     // {ext, timer, soft}, first stage
    logic [2:0]  mip_q, mip_d;               // second stage, visible in mip

    logic [NCNT-1:0][COUNTER_WIDTH-1:0] cnt;
    logic [NCNT-1:0] cnt_inc, cnt_inh, cnt_wr_lo, cnt_wr_hi;

    assign cnt_inc = {hpm_event, retired, 1'b1};
    assign cnt_inh = {inhibit_q[3 +: NUM_HPM], inhibit_q[2], inhibit_q[0]};

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        assign cnt_wr_lo[k] = write_enable && (write_address == {7'b1011000, cnt_off(k)});
        assign cnt_wr_hi[k] = write_enable && (write_address == {7'b1011100, cnt_off(k)});
        csr_counter #(.W(COUNTER_WIDTH)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (cnt_inc[k]),
            .inhibit (cnt_inh[k]),
            .wr_lo   (cnt_wr_lo[k]),
            .wr_hi   (cnt_wr_hi[k]),
            .wdata   (write_data),
            .cnt     (cnt[k])
        );
    end

    // ---------------- read port ----------------
    logic        is_cnt;
    logic [63:0] cnt_sel;

    always_comb begin
        // 0xB**/0xC** with [6:5]=0 covers mcycle..mhpmcounter31 and their
        // high halves, excluding offset 1 (time).
        is_cnt  = (read_address[11:8] == 4'hB || read_address[11:8] == 4'hC) &&
                  (read_address[6:5] == 2'b00) && (read_address[4:0] != 5'd1);
        cnt_sel = '0;
        for (int k = 0; k < NCNT; k++)
            if (read_address[4:0] == cnt_off(k)) cnt_sel[COUNTER_WIDTH-1:0] = cnt[k];

        read_data = '0;
        readable  = 1'b1;
        if (is_cnt) begin
            read_data = read_address[7] ? cnt_sel[63:32] : cnt_sel[31:0];
        end else begin
            case (read_address)
                12'h300: read_data = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
                12'h301: read_data = 32'h4000_0100;
                12'h304: read_data = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
                12'h305: read_data = {mtvec_base_q, mtvec_mode_q};
                12'h320: read_data = inhibit_q;
                12'h340: read_data = mscratch_q;
                12'h341: read_data = mepc_q;
                12'h342: read_data = {mcause_irq_q, 27'b0, mcause_code_q};
                12'h343: read_data = mtval_q;
                12'h344: read_data = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
                12'hF14: read_data = HART_ID;
                // mhpmevent3..31 exist but read as zero
                default: readable = (read_address >= 12'h323) && (read_address <= 12'h33F);
            endcase
        end
        writeable = readable && (read_address[11:10] != 2'b11);
    end

    // ---------------- next state ----------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mtvec_base_d   = mtvec_base_q;
        mtvec_mode_d   = mtvec_mode_q;
        inhibit_d      = inhibit_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_irq_d   = mcause_irq_q;
        mcause_code_d  = mcause_code_q;
        mtval_d        = mtval_q;
        irq_sync_d     = {ext_irq, timer_irq, soft_irq};
        mip_d          = irq_sync_q;

        if (write_enable) begin
            case (write_address)
                12'h304: mie_en_d = {write_data[11], write_data[7], write_data[3]};
                12'h305: begin
                    mtvec_base_d = write_data[31:2];
                    if (write_data[1:0] == 2'b00 || (write_data[1:0] == 2'b01 && VECTORED_EN))
                        mtvec_mode_d = write_data[1:0];
                end
                12'h320: inhibit_d  = write_data & INH_MASK;
                12'h340: mscratch_d = write_data;
                default: ;
            endcase
        end

        // mstatus/mepc/mcause/mtval: trap beats mret beats a CSR write.
        if (traped) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = {ecp[31:2], 2'b00};
            mcause_irq_d   = interupt;
            mcause_code_d  = trap_cause;
            mtval_d        = trap_value;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (write_enable) begin
            case (write_address)
                12'h300: begin
                    mstatus_mie_d  = write_data[3];
                    mstatus_mpie_d = write_data[7];
                end
                12'h341: mepc_d = {write_data[31:2], 2'b00};
                12'h342: begin
                    mcause_irq_d  = write_data[31];
                    mcause_code_d = write_data[3:0];
                end
                12'h343: mtval_d = write_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= '0;
            mtvec_base_q   <= MTVEC_RESET[31:2];
            mtvec_mode_q   <= MODE_RST;
            inhibit_q      <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_irq_q   <= 1'b0;
            mcause_code_q  <= '0;
            mtval_q        <= '0;
            irq_sync_q     <= '0;
            mip_q          <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mtvec_base_q   <= mtvec_base_d;
            mtvec_mode_q   <= mtvec_mode_d;
            inhibit_q      <= inhibit_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_irq_q   <= mcause_irq_d;
            mcause_code_q  <= mcause_code_d;
            mtval_q        <= mtval_d;
            irq_sync_q     <= irq_sync_d;
            mip_q          <= mip_d;
        end
    end

    // ---------------- outputs ----------------
    logic [2:0] irq_en;
    assign irq_en      = mip_q & mie_en_q;
    assign irq_pending = mstatus_mie_q & (|irq_en);
    // Priority: external (11) > software (3) > timer (7).
    assign irq_cause   = !irq_pending ? 4'd0 :
                         irq_en[2]    ? 4'd11 :
                         irq_en[0]    ? 4'd3  : 4'd7;
    assign trap_vector = {mtvec_base_q, 2'b00} +
                         ((mtvec_mode_q == 2'b01 && interupt) ? {26'b0, trap_cause, 2'b00} : 32'b0);
    assign mret_vector = mepc_q;
endmodule

// File: tb/tb_csr_machine.sv
module tb_csr_machine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] read_address = '0;
    logic        write_enable = 1'b0;
    logic [11:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic        retired = 1'b0;
    logic [3:0]  hpm_event = '0;
    logic        traped = 1'b0, mret = 1'b0, interupt = 1'b0;
    logic [31:0] ecp = '0, trap_value = '0;
    logic [3:0]  trap_cause = '0;
    logic        ext_irq = 1'b0, timer_irq = 1'b0, soft_irq = 1'b0;

    logic [31:0] rd_data, trap_vector, mret_vector;
    logic        rd_ok, wr_ok, irq_pending;
    logic [3:0]  irq_cause;
    logic [31:0] nv_rd_data, nv_trap_vector, nv_mret_vector;
    logic        nv_rd_ok, nv_wr_ok, nv_irq_pending;
    logic [3:0]  nv_irq_cause;

    always #5 clk = ~clk;

    csr_machine dut (
        .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_data(rd_data),
        .readable(rd_ok), .writeable(wr_ok), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data), .retired(retired),
        .hpm_event(hpm_event), .traped(traped), .mret(mret), .ecp(ecp),
        .trap_cause(trap_cause), .interupt(interupt), .trap_value(trap_value),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
        .irq_pending(irq_pending), .irq_cause(irq_cause),
        .trap_vector(trap_vector), .mret_vector(mret_vector)
    );

    // Non-vectored variant with a nonzero hart id and an illegal reset mode.
    csr_machine #(.HART_ID(32'h5), .MTVEC_RESET(32'h0000_0103), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_data(nv_rd_data),
        .readable(nv_rd_ok), .writeable(nv_wr_ok), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data), .retired(retired),
        .hpm_event(hpm_event), .traped(traped), .mret(mret), .ecp(ecp),
        .trap_cause(trap_cause), .interupt(interupt), .trap_value(trap_value),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
        .irq_pending(nv_irq_pending), .irq_cause(nv_irq_cause),
        .trap_vector(nv_trap_vector), .mret_vector(nv_mret_vector)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        read_address = a;
        #1;
    endtask

    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_data;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h301, 32'h4000_0100, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'hF14, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h305, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h300, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h344, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h123, 32'h0,         1'b0, 1'b0});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'h330, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'hB1F, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'hC01, 32'h0,         1'b0, 1'b0});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'hC83, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{1'b0, 12'h000, 32'h0,         12'hB01, 32'h0,         1'b0, 1'b0});
        tbl.push_back('{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h341, 32'h1234_5677, 12'h341, 32'h1234_5674, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h342, 32'hFFFF_FFFF, 12'h342, 32'h8000_000F, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h343, 32'hA5A5_A5A5, 12'h343, 32'hA5A5_A5A5, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h301, 32'h0,         12'h301, 32'h4000_0100, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h330, 32'hFFFF_FFFF, 12'h330, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h304, 32'h0,         12'h304, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_0088, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h300, 32'h0,         12'h300, 32'h0,         1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'h320, 32'hFFFF_FFFF, 12'h320, 32'h0000_007D, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 12'hF14, 32'h1234_5678, 12'hF14, 32'h0,         1'b1, 1'b0});
        tbl.push_back('{1'b1, 12'h320, 32'h0,         12'h320, 32'h0,         1'b1, 1'b1});

        // ---- reset state ----
        tick(); tick(); tick();
        chk("rst_irq_pending", 32'(irq_pending), 32'h0);
        chk("rst_irq_cause",   32'(irq_cause),   32'h0);
        chk("rst_mret_vector", mret_vector,      32'h0);
        chk("rst_trap_vector", trap_vector,      32'h0);
        #1 rst_n = 1'b1;
        rd(12'hB00); chk("rst_mcycle", rd_data, 32'h0);
        rd(12'h305); chk("nv_rst_mtvec", nv_rd_data, 32'h0000_0100);
        rd(12'hF14); chk("nv_mhartid", nv_rd_data, 32'h5);

        // ---- table-driven decode / WARL checks ----
        foreach (tbl[i]) begin
            write_enable  = tbl[i].we;
            write_address = tbl[i].waddr;
            write_data    = tbl[i].wdata;
            read_address  = tbl[i].raddr;
            tick();
            write_enable  = 1'b0;
            #1;
            chk($sformatf("tbl%0d_data", i), rd_data,       tbl[i].exp_data);
            chk($sformatf("tbl%0d_rd", i),   32'(rd_ok),    32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_wr", i),   32'(wr_ok),    32'(tbl[i].exp_wr));
        end

        // ---- asynchronous reset mid-operation ----
        rst_n = 1'b0;
        rd(12'h340); chk("arst_mscratch", rd_data, 32'h0);
        rd(12'h342); chk("arst_mcause", rd_data, 32'h0);
        chk("arst_mret_vector", mret_vector, 32'h0);
        tick(); tick();
        #1 rst_n = 1'b1;

        // ---- mcycle counting and inhibit ----
        rd(12'hB00); chk("cyc0", rd_data, 32'd0);
        tick(); rd(12'hB00); chk("cyc1", rd_data, 32'd1);
        tick(); rd(12'hB00); chk("cyc2", rd_data, 32'd2);
        csr_wr(12'h320, 32'h1); rd(12'hB00); chk("cyc_inh_wr", rd_data, 32'd3);
        tick(); rd(12'hB00); chk("cyc_frozen1", rd_data, 32'd3);
        tick(); rd(12'hB00); chk("cyc_frozen2", rd_data, 32'd3);
        csr_wr(12'h320, 32'h0); rd(12'hB00); chk("cyc_uninh_wr", rd_data, 32'd3);
        tick(); rd(12'hB00); chk("cyc_resume", rd_data, 32'd4);

        // ---- minstret ----
        rd(12'hB02); chk("instret0", rd_data, 32'd0);
        retired = 1'b1; tick(); tick(); retired = 1'b0;
        rd(12'hB02); chk("instret2", rd_data, 32'd2);
        rd(12'hC02); chk("instret2_shadow", rd_data, 32'd2);

        // ---- HPM counters ----
        hpm_event = 4'b0101; tick(); tick(); tick(); hpm_event = 4'b0000;
        rd(12'hB03); chk("hpm3", rd_data, 32'd3);
        rd(12'hB04); chk("hpm4", rd_data, 32'd0);
        rd(12'hB05); chk("hpm5", rd_data, 32'd3);
        rd(12'hC85); chk("hpm5h", rd_data, 32'd0);
        hpm_event = 4'b0101;
        csr_wr(12'h320, 32'h8);
        tick(); tick(); hpm_event = 4'b0000;
        rd(12'hB03); chk("hpm3_inh", rd_data, 32'd4);
        rd(12'hB05); chk("hpm5_run", rd_data, 32'd6);
        csr_wr(12'h320, 32'h0);

        // ---- 64-bit wrap ----
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB00); chk("wrap_pre_lo", rd_data, 32'hFFFF_FFFF);
        rd(12'hB80); chk("wrap_pre_hi", rd_data, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00); chk("wrap_lo", rd_data, 32'h0);
        rd(12'hB80); chk("wrap_hi", rd_data, 32'h0);
        rd(12'hC80); chk("wrap_hi_shadow", rd_data, 32'h0);

        // ---- timer interrupt, vectored trap ----
        csr_wr(12'h300, 32'h8);
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h305, 32'h0000_1001);
        rd(12'h305);
        chk("mtvec_vec", rd_data, 32'h0000_1001);
        chk("nv_mtvec_mode", nv_rd_data, 32'h0000_1000);
        timer_irq = 1'b1;
        chk("tmr_pend_c0", 32'(irq_pending), 32'h0);
        tick(); chk("tmr_pend_c1", 32'(irq_pending), 32'h0);
        tick(); chk("tmr_pend_c2", 32'(irq_pending), 32'h1);
        chk("tmr_cause", 32'(irq_cause), 32'd7);
        rd(12'h344); chk("mip_mtip", rd_data, 32'h80);
        interupt = 1'b1; trap_cause = 4'd7; #1;
        chk("trap_vec_irq", trap_vector, 32'h0000_101C);
        chk("nv_trap_vec", nv_trap_vector, 32'h0000_1000);
        interupt = 1'b0; #1;
        chk("trap_vec_exc", trap_vector, 32'h0000_1000);
        traped = 1'b1; interupt = 1'b1; ecp = 32'h200; trap_value = 32'h55;
        tick();
        traped = 1'b0; interupt = 1'b0;
        rd(12'h300); chk("trap_mstatus", rd_data, 32'h80);
        rd(12'h342); chk("trap_mcause", rd_data, 32'h8000_0007);
        rd(12'h341); chk("trap_mepc", rd_data, 32'h200);
        rd(12'h343); chk("trap_mtval", rd_data, 32'h55);
        chk("trap_pend_masked", 32'(irq_pending), 32'h0);
        chk("trap_mret_vector", mret_vector, 32'h200);
        mret = 1'b1; tick(); mret = 1'b0;
        rd(12'h300); chk("mret_mstatus", rd_data, 32'h88);
        chk("mret_pend", 32'(irq_pending), 32'h1);

        // ---- interrupt priority ----
        ext_irq = 1'b1; soft_irq = 1'b1;
        csr_wr(12'h304, 32'h888);
        chk("prio_c1", 32'(irq_cause), 32'd7);
        tick(); chk("prio_ext", 32'(irq_cause), 32'd11);
        ext_irq = 1'b0;
        tick(); chk("prio_drop_c1", 32'(irq_cause), 32'd11);
        tick(); chk("prio_soft", 32'(irq_cause), 32'd3);

        // ---- trap + mret + mepc write in one cycle ----
        csr_wr(12'h300, 32'h8);
        traped = 1'b1; mret = 1'b1; ecp = 32'h8000_0006; trap_cause = 4'd2;
        trap_value = 32'h0; write_enable = 1'b1; write_address = 12'h341; write_data = 32'h4;
        tick();
        traped = 1'b0; mret = 1'b0; write_enable = 1'b0;
        rd(12'h341); chk("same_mepc", rd_data, 32'h8000_0004);
        rd(12'h300); chk("same_mstatus", rd_data, 32'h80);
        rd(12'h342); chk("same_mcause", rd_data, 32'h2);
        chk("same_mret_vector", mret_vector, 32'h8000_0004);

        // ---- illegal mtvec mode ----
        csr_wr(12'h305, 32'h0000_2002);
        rd(12'h305);
        chk("mtvec_mode2", rd_data, 32'h0000_2001);
        chk("nv_mtvec_mode2", nv_rd_data, 32'h0000_2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
